// File: rtl/pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter -- parametrised program counter for the luna CPU datapath.
//
// Drives the instruction fetch address and executes one control-unit command
// per cycle: absolute load, call, return, signed relative branch, increment
// or hold. Everything is registered; there is no combinational path from any
// input to any output.
//
// Optional feature macro: PC_RSTACK_EN
//   defined     -> hardware return-address stack (LIFO) plus call/ret handling
//                  and live stack flags
//   not defined -> no stack storage or pointer; call_en/ret_en are ignored;
//                  stack_full = 0, stack_empty = 1, stack_err = 0
//
// Parameters
//   WIDTH        counter / address width in bits (>= 2)
//   RESET_VALUE  value of data_out after reset
//   STACK_DEPTH  number of return-stack entries (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           increment by one
//   write_en     absolute load of data_in
//   data_in      load / call target
//   rel_en       relative branch by offset (two's complement)
//   offset       branch offset
//   call_en      push data_out + 1 and jump to data_in
//   ret_en       pop return address into the counter
//   data_out     current counter value
//   wrap         one-cycle pulse after an increment from all ones to zero
//   stack_full   stack holds STACK_DEPTH entries
//   stack_empty  stack holds no entries
//   stack_err    sticky overflow/underflow flag, cleared only by reset
//
// Command handshake: there is no back-pressure. Every command sampled on a
// rising edge with rst_n high is consumed on that edge. When several command
// bits are high, the priority write_en > call_en > ret_en > rel_en > en picks
// a single winner and the rest are dropped.
// -----------------------------------------------------------------------------
module pc_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             write_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rel_en,
    input  logic [WIDTH-1:0] offset,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [WIDTH-1:0] data_out,
    output logic             wrap,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] pc_plus1;

    assign pc_plus1 = pc_q + ONE;

`ifdef PC_RSTACK_EN
    // Pointer counts stored entries, so it needs to reach STACK_DEPTH itself.
    localparam int PTR_W = (STACK_DEPTH > 0) ? $clog2(STACK_DEPTH + 1) : 1;
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STACK_DEPTH);

    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             err_q, err_d;
    logic             push;
    logic [PTR_W-1:0] ptr_m1;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             full;
    logic             empty;

    assign full     = (ptr_q == PTR_FULL);
    assign empty    = (ptr_q == '0);
    assign ptr_m1   = ptr_q - PTR_ONE;
    // Push writes the slot just above the top; pop reads the top itself.
    // Truncation is safe: push only happens when ptr_q < STACK_DEPTH and the
    // pop index is only used when the stack is not empty.
    assign push_idx = ptr_q[IDX_W-1:0];
    assign pop_idx  = ptr_m1[IDX_W-1:0];
`else
    // Keeps the ignored command inputs and the unused depth parameter
    // referenced in the stackless build.
    logic unused_stack_inputs;
    assign unused_stack_inputs = call_en ^ ret_en ^ (STACK_DEPTH == 0);
`endif

    // Next-state decode, fixed priority.
    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
`ifdef PC_RSTACK_EN
        ptr_d  = ptr_q;
        err_d  = err_q;
        push   = 1'b0;
`endif
        if (write_en) begin
            pc_d = data_in;
        end
`ifdef PC_RSTACK_EN
        else if (call_en) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                push  = 1'b1;
                ptr_d = ptr_q + PTR_ONE;
                pc_d  = data_in;
            end
        end
        else if (ret_en) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                ptr_d = ptr_m1;
                pc_d  = stack_q[pop_idx];
            end
        end
`endif
        else if (rel_en) begin
            // Truncated sum gives modular wrap both ways; no wrap pulse.
            pc_d = pc_q + offset;
        end
        else if (en) begin
            pc_d   = pc_plus1;
            wrap_d = &pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef PC_RSTACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    // Entry storage is deliberately not reset; the pointer alone defines
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_plus1;
        end
    end

    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;
`else
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif

    assign data_out = pc_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_pc_counter.sv
// -----------------------------------------------------------------------------
// tb_pc_counter -- self-checking bench for pc_counter (WIDTH=16,
// RESET_VALUE=0x0100, STACK_DEPTH=4). Adapts to PC_RSTACK_EN.
// -----------------------------------------------------------------------------
module tb_pc_counter;

    localparam int          W   = 16;
    localparam logic [15:0] RV  = 16'h0100;
    localparam int          D   = 4;
    localparam int unsigned MOD = 32'd65536;
`ifdef PC_RSTACK_EN
    localparam bit HAS_STACK = 1'b1;
`else
    localparam bit HAS_STACK = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          en, write_en, rel_en, call_en, ret_en;
    logic [W-1:0]  data_in, offset;
    logic [W-1:0]  data_out;
    logic          wrap, stack_full, stack_empty, stack_err;

    pc_counter #(.WIDTH(W), .RESET_VALUE(RV), .STACK_DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .write_en   (write_en),
        .data_in    (data_in),
        .rel_en     (rel_en),
        .offset     (offset),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .data_out   (data_out),
        .wrap       (wrap),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string name, input logic [15:0] pc, input logic full,
                             input logic empty, input logic err);
        chk({name, "/pc"},    32'(data_out),    32'(pc));
        chk({name, "/full"},  32'(stack_full),  32'(full));
        chk({name, "/empty"}, 32'(stack_empty), 32'(empty));
        chk({name, "/err"},   32'(stack_err),   32'(err));
    endtask

    // ---------------- driver ----------------
    // Applies one command, waits for the edge, then settles 1 time unit.
    task automatic drive(input logic we, input logic call, input logic ret, input logic rel,
                         input logic e, input logic [15:0] din, input logic [15:0] off);
        write_en = we;
        call_en  = call;
        ret_en   = ret;
        rel_en   = rel;
        en       = e;
        data_in  = din;
        offset   = off;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: checked before any clock edge, released at negedge.
    task automatic apply_reset(input string name);
        write_en = 0; call_en = 0; ret_en = 0; rel_en = 0; en = 0;
        rst_n = 1'b0;
        #2;
        chk_state(name, RV, 1'b0, 1'b1, 1'b0);
        chk({name, "/wrap"}, 32'(wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    int unsigned m_pc;
    logic        m_wrap;
    logic        m_err;
    int unsigned m_stk[$];

    function automatic void model_reset();
        m_pc   = 32'(RV);
        m_wrap = 1'b0;
        m_err  = 1'b0;
        m_stk.delete();
    endfunction

    function automatic void model_step(input logic we, input logic call, input logic ret,
                                       input logic rel, input logic e,
                                       input logic [15:0] din, input logic [15:0] off);
        int unsigned old;
        old    = m_pc;
        m_wrap = 1'b0;
        if (we) begin
            m_pc = 32'(din);
        end else if (HAS_STACK && call) begin
            if (m_stk.size() == D) m_err = 1'b1;
            else begin
                m_stk.push_back((old + 1) % MOD);
                m_pc = 32'(din);
            end
        end else if (HAS_STACK && ret) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (rel) begin
            m_pc = (old + 32'(off)) % MOD;
        end else if (e) begin
            m_pc   = (old + 1) % MOD;
            m_wrap = (old == MOD - 1);
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we, call, ret, rel, e;
        logic [15:0] din, off;
        logic [15:0] exp_pc;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[15];

    initial begin
        //           we call ret rel en  din       off       exp_pc    wrap
        vecs[0]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0101, 1'b0};
        vecs[1]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0102, 1'b0};
        vecs[2]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0103, 1'b0};
        vecs[3]  = '{1, 0, 0, 0, 0, 16'hFFFE, 16'h0000, 16'hFFFE, 1'b0};
        vecs[4]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
        vecs[5]  = '{0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010, 1'b0};
        vecs[8]  = '{0, 0, 0, 1, 1, 16'h0000, 16'hFFF8, 16'h0008, 1'b0};
        vecs[9]  = '{0, 0, 0, 1, 0, 16'h0000, 16'hFFF0, 16'hFFF8, 1'b0};
        vecs[10] = '{0, 0, 0, 1, 0, 16'h0000, 16'h0020, 16'h0018, 1'b0};
        vecs[11] = '{1, 0, 0, 1, 1, 16'h1234, 16'h0005, 16'h1234, 1'b0};
        vecs[12] = '{1, 1, 1, 0, 0, 16'h0042, 16'h0000, 16'h0042, 1'b0};
        vecs[13] = '{1, 0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
        vecs[14] = '{0, 0, 0, 1, 0, 16'h0000, 16'h0001, 16'h0000, 1'b0};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        write_en = 0; call_en = 0; ret_en = 0; rel_en = 0; en = 0;
        data_in = '0; offset = '0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset("reset0");

        // Table: increment, load, wrap pulse, relative branch, priority.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].we, vecs[i].call, vecs[i].ret, vecs[i].rel, vecs[i].e,
                  vecs[i].din, vecs[i].off);
            chk($sformatf("vec%0d/pc", i),    32'(data_out),    32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d/wrap", i),  32'(wrap),        32'(vecs[i].exp_wrap));
            chk($sformatf("vec%0d/empty", i), 32'(stack_empty), 32'd1);
            chk($sformatf("vec%0d/err", i),   32'(stack_err),   32'd0);
        end

`ifdef PC_RSTACK_EN
        // Nested call / return.
        drive(1, 0, 0, 0, 0, 16'h0010, 16'h0);  chk_state("ld10",  16'h0010, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 16'h0200, 16'h0);  chk_state("call1", 16'h0200, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 16'h0300, 16'h0);  chk_state("call2", 16'h0300, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 16'h0000, 16'h7);  chk_state("ret1",  16'h0201, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0);  chk_state("ret2",  16'h0011, 0, 1, 0);
        // Call immediately followed by ret.
        drive(0, 1, 0, 0, 0, 16'h0500, 16'h0);  chk_state("call3", 16'h0500, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0);  chk_state("ret3",  16'h0012, 0, 1, 0);
        // Overflow on fifth call.
        drive(0, 1, 0, 0, 0, 16'h1000, 16'h0);
        drive(0, 1, 0, 0, 0, 16'h1001, 16'h0);
        drive(0, 1, 0, 0, 0, 16'h1002, 16'h0);
        drive(0, 1, 0, 0, 0, 16'h1003, 16'h0);  chk_state("call4x", 16'h1003, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 16'h1004, 16'h0);  chk_state("ovf",    16'h1003, 1, 0, 1);
        drive(1, 1, 1, 0, 0, 16'h0042, 16'h0);  chk_state("we_all", 16'h0042, 1, 0, 1);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0);  chk_state("pop4",   16'h1003, 0, 0, 1);
        apply_reset("reset1");
        // Underflow.
        drive(0, 0, 1, 0, 1, 16'h0000, 16'h0);  chk_state("unf",    RV, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 16'h0000, 16'h0);  chk_state("inc_ae", 16'h0101, 0, 1, 1);
`else
        // Stackless: call/ret ignored and out of the priority chain.
        drive(1, 0, 0, 0, 0, 16'h0300, 16'h0);  chk_state("ld300",  16'h0300, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 16'h0777, 16'h0);  chk_state("call_n", 16'h0300, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 16'h0000, 16'h0);  chk_state("ret_n",  16'h0300, 0, 1, 0);
        drive(0, 1, 1, 0, 1, 16'h0777, 16'h0);  chk_state("call_en",16'h0301, 0, 1, 0);
        drive(0, 1, 0, 1, 1, 16'h0777, 16'h10); chk_state("call_rl",16'h0311, 0, 1, 0);
        apply_reset("reset1");
`endif

        // Randomised commands against the reference model.
        apply_reset("reset2");
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            logic        we, call, ret, rel, e;
            logic [15:0] din, off;
            if ($urandom_range(0, 149) == 0) begin
                apply_reset($sformatf("rnd_rst%0d", c));
                model_reset();
            end else begin
                we   = ($urandom_range(0, 9) == 0);
                call = ($urandom_range(0, 4) == 0);
                ret  = ($urandom_range(0, 4) == 0);
                rel  = ($urandom_range(0, 4) == 0);
                e    = ($urandom_range(0, 9) < 6);
                din  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                                   : 16'($urandom);
                off  = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                   : 16'($urandom_range(0, 8) - 4);
                drive(we, call, ret, rel, e, din, off);
                model_step(we, call, ret, rel, e, din, off);
                chk("rnd/pc",    32'(data_out),    m_pc);
                chk("rnd/wrap",  32'(wrap),        32'(m_wrap));
                chk("rnd/full",  32'(stack_full),  32'(HAS_STACK && (m_stk.size() == D)));
                chk("rnd/empty", 32'(stack_empty), 32'(m_stk.size() == 0));
                chk("rnd/err",   32'(stack_err),   32'(m_err));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
